increment_feeder: RTL

- Upstream stage for the counter/LED block.
- Accepts 32-bit increment words on a valid/ready stream and buffers them in a small FIFO.
- Drives the counter block's `enable`/`value` pair with one-cycle `enable` pulses, spaced so that every pulse is sampled in the counter's idle state.
- Holds `value` stable until the counter has added it.

---
 rtl/increment_feeder_if.sv | 19 +
 rtl/increment_feeder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/increment_feeder_if.sv
// Increment-word stream between an upstream producer and the increment feeder.
// The producer drives valid/data; the feeder answers with ready.
interface increment_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/increment_feeder.sv
// Increment feeder: buffers 32-bit increment words in a small FIFO and hands
// them to the counter block as one-cycle enable pulses. Pulses are spaced at
// least GAP cycles apart so the counter is always idle when a pulse arrives,
// and value is held until the next issue.
module increment_feeder #(
  parameter int DEPTH = 4,  // FIFO entries, power of two, >= 2
  parameter int GAP   = 3   // minimum cycles between enable pulses, >= 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  increment_feeder_if.slave        up,
  output logic                     enable,
  output logic [31:0]              value,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(GAP);

  localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_EMPTY   = {CNT_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};
  // After an issue the counter needs GAP-1 further cycles before it is idle.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(GAP - 1);

  // Storage and state
  logic [31:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [HOLD_W-1:0] hold_r;
  logic              enable_r;
  logic [31:0]       value_r;

  // Decoded conditions
  logic full_s;
  logic empty_s;
  logic hold_zero_s;
  logic ready_s;
  logic push_s;
  logic issue_s;

  // Occupancy flags come from the count so that full and empty are never
  // confused when the pointers coincide.
  always_comb begin
    full_s      = 1'b0;
    empty_s     = 1'b0;
    hold_zero_s = 1'b0;
    if (count_r == CNT_FULL) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (count_r == CNT_EMPTY) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if (hold_r == HOLD_ZERO) begin
      hold_zero_s = 1'b1;
    end else begin
      hold_zero_s = 1'b0;
    end
  end

  // Handshake and issue decisions; ready is forced low during reset so no
  // word can slip in while the FIFO is being cleared.
  always_comb begin
    ready_s = 1'b0;
    push_s  = 1'b0;
    issue_s = 1'b0;
    if (RST) begin
      ready_s = 1'b0;
    end else begin
      ready_s = !full_s;
    end
    push_s  = up.in_valid && ready_s;
    issue_s = !empty_s && hold_zero_s;
  end

  assign up.in_ready = ready_s;

  // FIFO storage write; contents need no reset because the count gates reads.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= up.in_data;
    end
  end

  // Write pointer advances on every accepted word, wrapping modulo DEPTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (push_s) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer advances on every issued word, wrapping modulo DEPTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_r <= {PTR_W{1'b0}};
    end else if (issue_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy count; a coincident push and issue leave it unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= CNT_EMPTY;
    end else begin
      case ({push_s, issue_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Hold counter spaces the pulses so each one lands in the counter's idle state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_r <= HOLD_ZERO;
    end else if (issue_s) begin
      hold_r <= HOLD_RELOAD;
    end else if (!hold_zero_s) begin
      hold_r <= hold_r - HOLD_ONE;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Issue register: one-cycle enable pulse, value held until the next issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      enable_r <= 1'b0;
      value_r  <= 32'h0000_0000;
    end else if (issue_s) begin
      enable_r <= 1'b1;
      value_r  <= mem_r[rd_ptr_r];
    end else begin
      enable_r <= 1'b0;
      value_r  <= value_r;
    end
  end

  assign enable = enable_r;
  assign value  = value_r;
  assign level  = count_r;
  // Busy covers both buffered words and a pulse whose spacing window is open.
  assign busy   = !empty_s || !hold_zero_s;

endmodule
